// File: rtl/fp_addsub_resp_if.sv
// Streaming interface shared by the chunked modular-arithmetic blocks.
//   val/rdy : beat handshake, transfer when both are high
//   sop/eop : first / last beat of a packet
//   err     : packet-level error indication (result side)
//   dat     : beat payload, DAT_BITS wide
//   ctl     : request tag, CTL_BITS wide
// source/master drive a stream; sink/slave receive it.
interface if_axi_stream #(
    parameter int unsigned DAT_BITS = 8,
    parameter int unsigned CTL_BITS = 8
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport source (output val, sop, eop, err, dat, ctl, input rdy);
    modport sink   (input val, sop, eop, err, dat, ctl, output rdy);
    modport master (output val, sop, eop, err, dat, ctl, input rdy);
    modport slave  (input val, sop, eop, err, dat, ctl, output rdy);
endinterface

// File: rtl/fp_addsub_resp.sv
// Serial modular adder/subtractor responder.
// Accepts a request of DIV beats (a chunk in dat low half, b chunk in dat high half), computes
// (a+b) mod P or (a-b) mod P one ARITH_BITS chunk per beat, and returns DIV result beats,
// least-significant chunk first, with the request tag echoed.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_if    : request stream (sink), dat 2*ARITH_BITS, ctl CTL_BITS
//   o_if    : result stream (source), dat ARITH_BITS, ctl CTL_BITS, err flags malformed requests
module fp_addsub_resp #(
    parameter int unsigned          DAT_BITS   = 381,
    parameter int unsigned          ARITH_BITS = 64,
    parameter int unsigned          CTL_BITS   = 8,
    parameter int unsigned          SUBTRACT   = 0,
    parameter logic [DAT_BITS-1:0]  P          = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    if_axi_stream.sink     i_if,
    if_axi_stream.source   o_if
);

    localparam int unsigned DIV = (DAT_BITS + ARITH_BITS - 1) / ARITH_BITS;
    localparam int unsigned KW  = $clog2(DIV + 1);
    localparam int unsigned IW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW  = DIV * ARITH_BITS;
    localparam logic [PW-1:0] PExt = PW'(P);

    typedef enum logic [1:0] {StIn, StPad, StOut} state_e;

    state_e                state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic [KW-1:0]         k_q, k_d;
    logic [IW-1:0]         j_q, j_d;
    logic                  cin_q, cin_d;
    logic                  bw_q, bw_d;
    logic                  in_pkt_q, in_pkt_d;
    logic                  err_q, err_d;
    logic                  sel_q, sel_d;
    logic [CTL_BITS-1:0]   ctl_q, ctl_d;
    logic [ARITH_BITS-1:0] s_buf_q [DIV];
    logic [ARITH_BITS-1:0] s_buf_d [DIV];
    logic [ARITH_BITS-1:0] t_buf_q [DIV];
    logic [ARITH_BITS-1:0] t_buf_d [DIV];

    // Chunk datapath operands and results
    logic [ARITH_BITS-1:0] op_a, op_b, p_chunk;
    logic [KW-1:0]         k_eff;
    logic [IW-1:0]         op_idx;
    logic                  op_first;
    logic                  c_in, b_in;
    logic [ARITH_BITS:0]   s_wide, t_wide;
    logic                  cin_nx, bw_nx;

    function automatic logic sel_of(input logic cin, input logic bw);
        // Add: wrap past 2^N or non-negative s-P selects T. Sub: negative a-b selects T.
        if (SUBTRACT != 0) return bw;
        return cin | ~bw;
    endfunction

    // Operand selection: padding beats of a short packet are zero chunks.
    always_comb begin
        op_a     = i_if.dat[ARITH_BITS-1:0];
        op_b     = i_if.dat[2*ARITH_BITS-1:ARITH_BITS];
        op_first = i_if.sop || !in_pkt_q;
        k_eff    = op_first ? '0 : k_q;
        if (state_q == StPad) begin
            op_a     = '0;
            op_b     = '0;
            op_first = 1'b0;
            k_eff    = k_q;
        end
        op_idx  = k_eff[IW-1:0];
        p_chunk = PExt[int'(op_idx)*ARITH_BITS +: ARITH_BITS];
        c_in    = op_first ? 1'b0 : cin_q;
        b_in    = op_first ? 1'b0 : bw_q;
    end

    // One chunk of both candidate chains: S = a op b, T = S corrected by P.
    always_comb begin
        if (SUBTRACT != 0) begin
            s_wide = {1'b0, op_a} - {1'b0, op_b} - (ARITH_BITS+1)'(b_in);
            t_wide = {1'b0, s_wide[ARITH_BITS-1:0]} + {1'b0, p_chunk} + (ARITH_BITS+1)'(c_in);
            bw_nx  = s_wide[ARITH_BITS];
            cin_nx = t_wide[ARITH_BITS];
        end else begin
            s_wide = {1'b0, op_a} + {1'b0, op_b} + (ARITH_BITS+1)'(c_in);
            t_wide = {1'b0, s_wide[ARITH_BITS-1:0]} - {1'b0, p_chunk} - (ARITH_BITS+1)'(b_in);
            cin_nx = s_wide[ARITH_BITS];
            bw_nx  = t_wide[ARITH_BITS];
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        j_d      = j_q;
        cin_d    = cin_q;
        bw_d     = bw_q;
        in_pkt_d = in_pkt_q;
        err_d    = err_q;
        sel_d    = sel_q;
        ctl_d    = ctl_q;
        s_buf_d  = s_buf_q;
        t_buf_d  = t_buf_q;

        unique case (state_q)
            StIn: begin
                if (i_if.val && rdy_q) begin
                    in_pkt_d = !i_if.eop;
                    if (i_if.sop) ctl_d = i_if.ctl;
                    if (!i_if.sop && !in_pkt_q) err_d = 1'b1;
                    if (k_eff < KW'(DIV)) begin
                        s_buf_d[op_idx] = s_wide[ARITH_BITS-1:0];
                        t_buf_d[op_idx] = t_wide[ARITH_BITS-1:0];
                        cin_d           = cin_nx;
                        bw_d            = bw_nx;
                        k_d             = k_eff + KW'(1);
                    end else begin
                        // Excess beat: dropped, chains keep their last state
                        err_d = 1'b1;
                    end
                    if (i_if.eop) begin
                        j_d = '0;
                        if (k_eff < KW'(DIV - 1)) begin
                            err_d   = 1'b1;
                            state_d = StPad;
                        end else begin
                            state_d = StOut;
                            sel_d   = sel_of(cin_d, bw_d);
                        end
                    end
                end
            end
            StPad: begin
                s_buf_d[op_idx] = s_wide[ARITH_BITS-1:0];
                t_buf_d[op_idx] = t_wide[ARITH_BITS-1:0];
                cin_d           = cin_nx;
                bw_d            = bw_nx;
                k_d             = k_q + KW'(1);
                if (k_q == KW'(DIV - 1)) begin
                    state_d = StOut;
                    sel_d   = sel_of(cin_nx, bw_nx);
                end
            end
            StOut: begin
                if (o_if.rdy) begin
                    if (j_q == IW'(DIV - 1)) begin
                        state_d  = StIn;
                        err_d    = 1'b0;
                        k_d      = '0;
                        in_pkt_d = 1'b0;
                        cin_d    = 1'b0;
                        bw_d     = 1'b0;
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
            end
            default: state_d = StIn;
        endcase

        rdy_d = (state_d == StIn);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIn;
            rdy_q    <= 1'b0;
            k_q      <= '0;
            j_q      <= '0;
            cin_q    <= 1'b0;
            bw_q     <= 1'b0;
            in_pkt_q <= 1'b0;
            err_q    <= 1'b0;
            sel_q    <= 1'b0;
            ctl_q    <= '0;
            for (int i = 0; i < int'(DIV); i++) begin
                s_buf_q[i] <= '0;
                t_buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            k_q      <= k_d;
            j_q      <= j_d;
            cin_q    <= cin_d;
            bw_q     <= bw_d;
            in_pkt_q <= in_pkt_d;
            err_q    <= err_d;
            sel_q    <= sel_d;
            ctl_q    <= ctl_d;
            s_buf_q  <= s_buf_d;
            t_buf_q  <= t_buf_d;
        end
    end

    assign i_if.rdy = rdy_q;

    // Result beats come straight from the held buffers, so they stay stable under backpressure.
    always_comb begin
        o_if.val = (state_q == StOut);
        o_if.sop = (state_q == StOut) && (j_q == '0);
        o_if.eop = (state_q == StOut) && (j_q == IW'(DIV - 1));
        o_if.err = (state_q == StOut) && err_q;
        o_if.ctl = ctl_q;
        o_if.dat = '0;
        o_if.dat[ARITH_BITS-1:0] = sel_q ? t_buf_q[j_q] : s_buf_q[j_q];
    end

endmodule

// File: tb/tb_fp_addsub_resp.sv
// Scoreboard bench for fp_addsub_resp: one add and one sub instance, 16-bit field, 8-bit chunks.
module tb_fp_addsub_resp;

    localparam logic [15:0] PMOD = 16'hFFF1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    if_axi_stream #(.DAT_BITS(16), .CTL_BITS(8)) add_in ();
    if_axi_stream #(.DAT_BITS(8),  .CTL_BITS(8)) add_out ();
    if_axi_stream #(.DAT_BITS(16), .CTL_BITS(8)) sub_in ();
    if_axi_stream #(.DAT_BITS(8),  .CTL_BITS(8)) sub_out ();

    fp_addsub_resp #(
        .DAT_BITS   (16),
        .ARITH_BITS (8),
        .CTL_BITS   (8),
        .SUBTRACT   (0),
        .P          (PMOD)
    ) u_add (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_if    (add_in.sink),
        .o_if    (add_out.source)
    );

    fp_addsub_resp #(
        .DAT_BITS   (16),
        .ARITH_BITS (8),
        .CTL_BITS   (8),
        .SUBTRACT   (1),
        .P          (PMOD)
    ) u_sub (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_if    (sub_in.sink),
        .o_if    (sub_out.source)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected beat: {err, sop, eop, ctl[7:0], dat[7:0]}
    logic [18:0] add_q [$];
    logic [18:0] sub_q [$];
    int add_eop_cyc = 0;
    int sub_eop_cyc = 0;
    bit chk_lat = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input bit sub, input logic [15:0] a, input logic [15:0] b);
        int unsigned r;
        if (sub) r = (32'(a) + 32'(PMOD) - 32'(b)) % 32'(PMOD);
        else     r = (32'(a) + 32'(b)) % 32'(PMOD);
        return 16'(r);
    endfunction

    task automatic push_exp(input bit sub, input logic [15:0] r, input logic [7:0] ctl,
                            input bit err);
        logic [18:0] b0, b1;
        b0 = {err, 1'b1, 1'b0, ctl, r[7:0]};
        b1 = {err, 1'b0, 1'b1, ctl, r[15:8]};
        if (sub) begin sub_q.push_back(b0); sub_q.push_back(b1); end
        else     begin add_q.push_back(b0); add_q.push_back(b1); end
    endtask

    task automatic mon(input bit sub, input logic val, input logic rdy, input logic err,
                       input logic sop, input logic eop, input logic [7:0] ctl,
                       input logic [7:0] dat);
        logic [18:0] e;
        int          lat;
        if (!(val && rdy)) return;
        if (sub ? (sub_q.size() == 0) : (add_q.size() == 0)) begin
            check(sub ? "sub_extra_beat" : "add_extra_beat", 32'(sub ? sub_q.size() : add_q.size()), 1);
        end else begin
            e = sub ? sub_q.pop_front() : add_q.pop_front();
            check(sub ? "sub_beat" : "add_beat", {13'b0, err, sop, eop, ctl, dat}, {13'b0, e});
        end
        if (chk_lat && sop) begin
            lat = cyc - (sub ? sub_eop_cyc : add_eop_cyc);
            check(sub ? "sub_latency" : "add_latency", lat, 1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (add_in.val && add_in.rdy && add_in.eop) add_eop_cyc = cyc;
            mon(1'b0, add_out.val, add_out.rdy, add_out.err, add_out.sop, add_out.eop,
                add_out.ctl, add_out.dat);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (sub_in.val && sub_in.rdy && sub_in.eop) sub_eop_cyc = cyc;
            mon(1'b1, sub_out.val, sub_out.rdy, sub_out.err, sub_out.sop, sub_out.eop,
                sub_out.ctl, sub_out.dat);
        end
    end

    task automatic drive_beat(input bit sub, input logic [15:0] dat, input bit sop, input bit eop,
                              input logic [7:0] ctl);
        int   n = 0;
        logic r;
        if (sub) begin
            sub_in.val = 1'b1; sub_in.dat = dat; sub_in.sop = sop; sub_in.eop = eop; sub_in.ctl = ctl;
        end else begin
            add_in.val = 1'b1; add_in.dat = dat; add_in.sop = sop; add_in.eop = eop; add_in.ctl = ctl;
        end
        @(negedge clk);
        r = sub ? sub_in.rdy : add_in.rdy;
        while (!r && n < 100) begin
            @(negedge clk);
            r = sub ? sub_in.rdy : add_in.rdy;
            n++;
        end
        if (!r) check(sub ? "sub_in_rdy_timeout" : "add_in_rdy_timeout", 32'(r), 1);
        @(posedge clk);
        #1;
        if (sub) begin sub_in.val = 1'b0; sub_in.sop = 1'b0; sub_in.eop = 1'b0; end
        else     begin add_in.val = 1'b0; add_in.sop = 1'b0; add_in.eop = 1'b0; end
    endtask

    task automatic send(input bit sub, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] ctl);
        push_exp(sub, model(sub, a, b), ctl, 1'b0);
        drive_beat(sub, {b[7:0], a[7:0]}, 1'b1, 1'b0, ctl);
        drive_beat(sub, {b[15:8], a[15:8]}, 1'b0, 1'b1, ctl);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((add_q.size() != 0 || sub_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(add_q.size() + sub_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add_in.val = 1'b0; add_in.sop = 1'b0; add_in.eop = 1'b0; add_in.err = 1'b0;
        add_in.dat = '0;   add_in.ctl = '0;
        sub_in.val = 1'b0; sub_in.sop = 1'b0; sub_in.eop = 1'b0; sub_in.err = 1'b0;
        sub_in.dat = '0;   sub_in.ctl = '0;
        add_out.rdy = 1'b1;
        sub_out.rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_add_in_rdy", 32'(add_in.rdy), 0);
        check("rst_add_out_val", 32'(add_out.val), 0);
        check("rst_add_out_dat", 32'(add_out.dat), 0);
        check("rst_sub_out_val", 32'(sub_out.val), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_add_in_rdy", 32'(add_in.rdy), 1);
        check("rel_sub_in_rdy", 32'(sub_in.rdy), 1);

        // Add: exact wrap to zero
        send(1'b0, 16'hFFF0, 16'h0001, 8'h0B);
        wait_drain();

        // Add with carry out of the top chunk, under output backpressure
        add_out.rdy = 1'b0;
        send(1'b0, 16'h8000, 16'h8000, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_val", 32'(add_out.val), 1);
            check("bp_dat_hold", 32'(add_out.dat), 32'h0F);
            check("bp_sop_hold", 32'(add_out.sop), 1);
            check("bp_in_rdy_low", 32'(add_in.rdy), 0);
        end
        @(posedge clk);
        #1;
        add_out.rdy = 1'b1;
        wait_drain();
        check("bp_in_rdy_back", 32'(add_in.rdy), 1);

        send(1'b0, 16'h1234, 16'h0001, 8'h33);
        wait_drain();

        // Sub: negative wrap, plain, equal operands
        send(1'b1, 16'h0001, 16'h0002, 8'hA1);
        send(1'b1, 16'h5000, 16'h1000, 8'hA2);
        send(1'b1, 16'hFFF0, 16'hFFF0, 8'hA3);
        wait_drain();

        // Malformed: single sop+eop beat, high chunk treated as zero
        push_exp(1'b0, 16'h0008, 8'h44, 1'b1);
        drive_beat(1'b0, 16'h0305, 1'b1, 1'b1, 8'h44);
        wait_drain();
        send(1'b0, 16'h0100, 16'h0200, 8'h45);
        wait_drain();

        // Reset while a result is being returned
        send(1'b0, 16'h4000, 16'h0001, 8'h66);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_val", 32'(add_out.val), 0);
        check("mid_rst_in_rdy", 32'(add_in.rdy), 0);
        check("mid_rst_pending", 32'(add_q.size()), 1);
        add_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_in_rdy", 32'(add_in.rdy), 1);
        send(1'b0, 16'h0003, 16'h0004, 8'h77);
        wait_drain();

        // Back-to-back random traffic with latency checks
        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 16'($urandom_range(0, 32'hFFF0)), 16'($urandom_range(0, 32'hFFF0)),
                 8'($urandom));
        end
        wait_drain();
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 16'($urandom_range(0, 32'hFFF0)), 16'($urandom_range(0, 32'hFFF0)),
                 8'($urandom));
        end
        wait_drain();
        chk_lat = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
